prefetch_buf: RTL and testbench

Buffered successor to the single-instruction fetch/branch unit. It keeps a parametrised FIFO of prefetched instructions ahead of the core and resolves JMP/JIZ/CAL/RET itself through an internal return-address stack. It also redirects to the interrupt vector. It sits between the instruction memory (1-cycle synchronous read) and the processor decode/execute stage.

---
 rtl/prefetch_buf.sv | 221 ++++++++++++++++++++++
 tb/tb_prefetch_buf.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buf.sv
// prefetch_buf
//   Instruction prefetch buffer with local branch resolution. Keeps a FIFO of
//   prefetched {instruction, address} entries in front of the core and resolves
//   JMP (12), JIZ (13), CAL (14) and RET (15) at consume time. CAL and RET use
//   an internal return-address stack. A taken redirect flushes the FIFO, drops
//   the read data arriving in that cycle and issues the target read in the same
//   cycle, so a redirect costs one bubble.
//
//   Optional feature macro: PREFETCH_ITR_EN
//     defined   : interrupt request is latched into a pending flag and taken on
//                 the next sequential consume (redirect to ITRADD, push return
//                 address, 1-cycle itr_ack)
//     undefined : itr ignored, itr_ack tied low
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   imem_addr/rd  instruction memory read request (data returns next cycle)
//   imem_data     instruction memory read data
//   opcode, operand, instr_addr, instr_vld   head of the prefetch FIFO
//   instr_rdy     core consumes the head when instr_vld & instr_rdy
//   acc_is_zero   JIZ condition, sampled at consume
//   itr, itr_ack  interrupt request / redirect acknowledge
//   stk_ovf/udf   sticky return-stack overflow / underflow flags
module prefetch_buf #(
  parameter int                MINSTW = 8,
  parameter int                NBOPCO = 7,
  parameter int                NBOPER = 9,
  parameter logic [MINSTW-1:0] ITRADD = '0,
  parameter int                FDEPTH = 4,
  parameter int                SDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [MINSTW-1:0]        imem_addr,
  output logic                     imem_rd,
  input  logic [NBOPCO+NBOPER-1:0] imem_data,
  output logic [NBOPCO-1:0]        opcode,
  output logic [NBOPER-1:0]        operand,
  output logic [MINSTW-1:0]        instr_addr,
  output logic                     instr_vld,
  input  logic                     instr_rdy,
  input  logic                     acc_is_zero,
  input  logic                     itr,
  output logic                     itr_ack,
  output logic                     stk_ovf,
  output logic                     stk_udf
);

  localparam int IW  = NBOPCO + NBOPER;
  localparam int PW  = $clog2(FDEPTH);
  localparam int CW  = PW + 1;
  localparam int SIW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam int SW  = $clog2(SDEPTH + 1);

  localparam logic [NBOPCO-1:0] OP_JMP = NBOPCO'(12);
  localparam logic [NBOPCO-1:0] OP_JIZ = NBOPCO'(13);
  localparam logic [NBOPCO-1:0] OP_CAL = NBOPCO'(14);
  localparam logic [NBOPCO-1:0] OP_RET = NBOPCO'(15);

  logic [MINSTW-1:0] r_fpc;
  logic [IW-1:0]     r_fifo_instr [FDEPTH];
  logic [MINSTW-1:0] r_fifo_addr  [FDEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_cnt;
  logic              r_infl;
  logic [MINSTW-1:0] r_infl_addr;
  logic [MINSTW-1:0] r_stk [SDEPTH];
  logic [SW-1:0]     r_sp;
  logic              r_ovf;
  logic              r_udf;

  logic [IW-1:0]     w_head_instr;
  logic [MINSTW-1:0] w_head_addr;
  logic [NBOPCO-1:0] w_op;
  logic              w_consume;
  logic              w_ret;
  logic              w_ctl_taken;
  logic              w_itr_take;
  logic              w_redirect;
  logic              w_push;
  logic              w_pop;
  logic              w_stk_empty;
  logic              w_stk_full;
  logic [MINSTW-1:0] w_pop_val;
  logic [MINSTW-1:0] w_ret_addr;
  logic [MINSTW-1:0] w_target;
  logic              w_space;

  assign w_head_instr = r_fifo_instr[r_rptr];
  assign w_head_addr  = r_fifo_addr[r_rptr];
  assign w_op         = w_head_instr[IW-1:NBOPER];

  assign instr_vld  = (r_cnt != '0);
  assign opcode     = w_op;
  assign operand    = w_head_instr[NBOPER-1:0];
  assign instr_addr = w_head_addr;

  assign w_consume   = instr_vld & instr_rdy;
  assign w_ret       = (w_op == OP_RET);
  assign w_ctl_taken = w_consume & ((w_op == OP_JMP) | ((w_op == OP_JIZ) & ~acc_is_zero) |
                                    (w_op == OP_CAL) | w_ret);

`ifdef PREFETCH_ITR_EN
  logic r_pend;

  // Interrupt only rides on a sequential consume; a taken control
  // instruction leaves it pending for the next consume.
  assign w_itr_take = r_pend & w_consume & ~w_ctl_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
    end else if (w_itr_take) begin
      r_pend <= itr;
    end else begin
      r_pend <= r_pend | itr;
    end
  end
`else
  logic w_unused_itr;
  assign w_unused_itr = itr;
  assign w_itr_take   = 1'b0;
`endif

  assign itr_ack    = w_itr_take;
  assign w_redirect = w_ctl_taken | w_itr_take;
  assign w_push     = (w_consume & (w_op == OP_CAL)) | w_itr_take;
  assign w_pop      = w_consume & w_ret;

  assign w_stk_empty = (r_sp == '0);
  assign w_stk_full  = (r_sp == SW'(SDEPTH));
  assign w_pop_val   = w_stk_empty ? '0 : r_stk[SIW'(r_sp - SW'(1))];
  assign w_ret_addr  = w_head_addr + MINSTW'(1);

  always_comb begin
    w_target = w_head_instr[MINSTW-1:0];
    if (w_itr_take) begin
      w_target = ITRADD;
    end else if (w_ret) begin
      w_target = w_pop_val;
    end
  end

  // Space check counts the read whose data is still on its way.
  assign w_space = ({1'b0, r_cnt} + {{CW{1'b0}}, r_infl}) < (CW+1)'(FDEPTH);

  // Reads are held off while reset is asserted; the first read goes out in
  // the cycle reset is released.
  assign imem_rd   = ~rst & (w_redirect | w_space);
  assign imem_addr = w_redirect ? w_target : r_fpc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc       <= '0;
      r_infl      <= 1'b0;
      r_infl_addr <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < FDEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_addr[i]  <= '0;
      end
    end else begin
      r_infl      <= imem_rd;
      r_infl_addr <= imem_addr;
      if (imem_rd) begin
        r_fpc <= imem_addr + MINSTW'(1);
      end
      if (w_redirect) begin
        // Flush wins over the write of the data arriving this cycle.
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (r_infl) begin
          r_fifo_instr[r_wptr] <= imem_data;
          r_fifo_addr[r_wptr]  <= r_infl_addr;
          r_wptr               <= r_wptr + PW'(1);
        end
        if (w_consume) begin
          r_rptr <= r_rptr + PW'(1);
        end
        if (r_infl && !w_consume) begin
          r_cnt <= r_cnt + CW'(1);
        end else if (!r_infl && w_consume) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      for (int i = 0; i < SDEPTH; i++) begin
        r_stk[i] <= '0;
      end
    end else if (w_push) begin
      if (w_stk_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_stk[SIW'(r_sp)] <= w_ret_addr;
        r_sp              <= r_sp + SW'(1);
      end
    end else if (w_pop) begin
      if (w_stk_empty) begin
        r_udf <= 1'b1;
      end else begin
        r_sp <= r_sp - SW'(1);
      end
    end
  end

  assign stk_ovf = r_ovf;
  assign stk_udf = r_udf;

endmodule

// File: tb/tb_prefetch_buf.sv
module tb_prefetch_buf;
  localparam int MINSTW = 8;
  localparam int NBOPCO = 7;
  localparam int NBOPER = 9;
  localparam int FDEPTH = 4;
  localparam int SDEPTH = 8;
  localparam int IW     = NBOPCO + NBOPER;
  localparam logic [MINSTW-1:0] ITRADD = 8'h10;
`ifdef PREFETCH_ITR_EN
  localparam bit ITR_EN = 1'b1;
`else
  localparam bit ITR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [MINSTW-1:0] imem_addr;
  logic              imem_rd;
  logic [IW-1:0]     imem_data = '0;
  logic [NBOPCO-1:0] opcode;
  logic [NBOPER-1:0] operand;
  logic [MINSTW-1:0] instr_addr;
  logic              instr_vld;
  logic              instr_rdy = 1'b0;
  logic              acc_is_zero = 1'b0;
  logic              itr = 1'b0;
  logic              itr_ack;
  logic              stk_ovf;
  logic              stk_udf;

  logic [IW-1:0] mem [256];

  prefetch_buf #(
    .MINSTW(MINSTW), .NBOPCO(NBOPCO), .NBOPER(NBOPER),
    .ITRADD(ITRADD), .FDEPTH(FDEPTH), .SDEPTH(SDEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .opcode(opcode), .operand(operand), .instr_addr(instr_addr),
    .instr_vld(instr_vld), .instr_rdy(instr_rdy), .acc_is_zero(acc_is_zero),
    .itr(itr), .itr_ack(itr_ack), .stk_ovf(stk_ovf), .stk_udf(stk_udf)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory, one cycle read latency
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // architectural reference model
  int cyc;
  int m_pc, m_fetch, m_age, m_out;
  int m_stk[$];
  bit m_ovf, m_udf, m_pend;
  int log_addr[$];
  int log_cyc[$];
  int ack_cyc[$];

  function automatic int lg(input int i);
    if (i < log_addr.size()) return log_addr[i];
    return -1;
  endfunction

  function automatic int lc(input int i);
    if (i < log_cyc.size()) return log_cyc[i];
    return -1;
  endfunction

  always @(negedge clk) begin : model
    logic [IW-1:0] w;
    int op, tgt;
    bit vld_e, cons, taken, itk;
    if (rst) begin
      m_pc = 0; m_fetch = 0; m_age = 0; m_out = 0;
      m_stk.delete(); m_ovf = 0; m_udf = 0; m_pend = 0; cyc = 0;
    end else begin
      vld_e = (m_age >= 2);
      chk("instr_vld", instr_vld, vld_e);
      chk("stk_ovf", stk_ovf, m_ovf);
      chk("stk_udf", stk_udf, m_udf);
      cons = vld_e && instr_rdy;
      taken = 0; itk = 0; tgt = 0;
      w = mem[m_pc[7:0]];
      if (vld_e) begin
        chk("instr_addr", instr_addr, m_pc);
        chk("opcode", opcode, w[15:9]);
        chk("operand", operand, w[8:0]);
      end
      if (cons) begin
        op = w[15:9];
        log_addr.push_back(m_pc);
        log_cyc.push_back(cyc);
        case (op)
          12: begin taken = 1; tgt = w[7:0]; end
          13: if (!acc_is_zero) begin taken = 1; tgt = w[7:0]; end
          14: begin taken = 1; tgt = w[7:0]; end
          15: begin
            taken = 1;
            if (m_stk.size() == 0) begin tgt = 0; m_udf = 1; end
            else tgt = m_stk.pop_back();
          end
          default: ;
        endcase
        if (!taken && ITR_EN && m_pend) begin itk = 1; tgt = ITRADD; end
        if (op == 14 || itk) begin
          if (m_stk.size() == SDEPTH) m_ovf = 1;
          else m_stk.push_back((m_pc + 1) % 256);
        end
      end
      chk("itr_ack", itr_ack, itk);
      if (itk) ack_cyc.push_back(cyc);
      if (taken || itk) begin
        m_fetch = tgt;
        chk("imem_rd_on_redirect", imem_rd, 1);
      end
      if (imem_rd) begin
        chk("imem_addr", imem_addr, m_fetch);
        m_fetch = (m_fetch + 1) % 256;
      end
      m_out = (taken || itk) ? 1 : m_out + int'(imem_rd) - int'(cons);
      chk("outstanding_le_depth", int'(m_out <= FDEPTH), 1);
      m_pend = ITR_EN && (itk ? itr : (m_pend | itr));
      m_pc   = (taken || itk) ? tgt : (cons ? (m_pc + 1) % 256 : m_pc);
      m_age  = (taken || itk) ? 1 : ((m_age < 2) ? m_age + 1 : 2);
      cyc++;
    end
  end

  // asserts reset away from the clock edge and checks outputs clear at once
  task automatic rst_on();
    @(posedge clk);
    #2;
    rst = 1'b1; instr_rdy = 1'b0; itr = 1'b0; acc_is_zero = 1'b0;
    #1;
    chk("rst_instr_vld", instr_vld, 0);
    chk("rst_imem_rd", imem_rd, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand", operand, 0);
    chk("rst_instr_addr", instr_addr, 0);
    chk("rst_itr_ack", itr_ack, 0);
    chk("rst_stk_ovf", stk_ovf, 0);
    chk("rst_stk_udf", stk_udf, 0);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    log_addr.delete(); log_cyc.delete(); ack_cyc.delete();
  endtask

  task automatic rst_off(input bit acc);
    @(posedge clk);
    #1;
    rst = 1'b0; instr_rdy = 1'b1; acc_is_zero = acc;
  endtask

  task automatic run(input int n, input int rdy_pct, input int acc_mode, input int itr_pct);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      instr_rdy = ($urandom_range(0, 99) < rdy_pct);
      itr = ($urandom_range(0, 99) < itr_pct);
      if (acc_mode == 2) acc_is_zero = $urandom_range(0, 1);
    end
  endtask

  function automatic logic [IW-1:0] ins(input int op, input int opr);
    return {7'(op), 9'(opr)};
  endfunction

  initial begin
    // sequential NOP stream
    rst_on(); rst_off(0); run(12, 100, 0, 0);
    chk("seq_first_cyc", lc(0), 2);
    chk("seq_addr5", lg(5), 5);
    chk("seq_cyc5", lc(5), 7);

    // JMP 0x40 at 3
    rst_on(); mem[3] = ins(12, 8'h40); rst_off(0); run(14, 100, 0, 0);
    chk("jmp_after", lg(4), 8'h40);
    chk("jmp_bubble_cyc", lc(4), 7);
    chk("jmp_next", lg(5), 8'h41);

    // JIZ 0x20 at 2, accumulator zero: falls through
    rst_on(); mem[2] = ins(13, 8'h20); rst_off(1); run(12, 100, 0, 0);
    chk("jiz_fall", lg(3), 3);
    // accumulator nonzero: taken
    rst_on(); mem[2] = ins(13, 8'h20); rst_off(0); run(12, 100, 0, 0);
    chk("jiz_taken", lg(3), 8'h20);

    // CAL 0x30 at 5, RET at 0x31
    rst_on(); mem[5] = ins(14, 8'h30); mem[8'h31] = ins(15, 0); rst_off(0); run(24, 100, 0, 0);
    chk("cal_5", lg(5), 5);
    chk("cal_tgt", lg(6), 8'h30);
    chk("cal_ret", lg(7), 8'h31);
    chk("cal_back", lg(8), 6);

    // nine nested CALs overflow the 8-entry stack; RET returns newest kept entry
    rst_on();
    for (int i = 0; i < 9; i++) mem[i] = ins(14, i + 1);
    mem[9] = ins(15, 0);
    rst_off(0); run(40, 100, 0, 0);
    chk("ovf_flag", stk_ovf, 1);
    chk("ovf_addr9", lg(9), 9);
    chk("ovf_ret", lg(10), 8);

    // RET on empty stack
    rst_on(); mem[1] = ins(15, 0); rst_off(0); run(12, 100, 0, 0);
    chk("udf_flag", stk_udf, 1);
    chk("udf_target", lg(2), 0);

`ifdef PREFETCH_ITR_EN
    // itr pulse during consume of 7 -> acked at consume of 8
    rst_on(); mem[8'h10] = ins(15, 0); rst_off(0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      itr = (k == 9);
    end
    chk("itr_ack_count", ack_cyc.size(), 1);
    if (ack_cyc.size() > 0) chk("itr_ack_cyc", ack_cyc[0], 10);
    chk("itr_at8", lg(8), 8);
    chk("itr_vector", lg(9), 8'h10);
    chk("itr_return", lg(10), 9);
`endif

    // stall for 10 cycles
    rst_on(); rst_off(0);
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      instr_rdy = !(k >= 5 && k <= 14);
      if (k == 14) begin
        chk("stall_rd_off", imem_rd, 0);
        chk("stall_outstanding", m_out, FDEPTH);
      end
    end
    chk("stall_resume_addr", lg(3), 3);
    chk("stall_resume_cyc", lc(3), 15);
    chk("stall_no_loss", lg(7), 7);
    chk("stall_rate", lc(7), 19);

    // randomized programs and handshakes
    for (int r = 0; r < 6; r++) begin
      rst_on();
      for (int i = 0; i < 256; i++) begin
        case ($urandom_range(0, 11))
          0: mem[i] = ins(12, $urandom_range(0, 511));
          1: mem[i] = ins(13, $urandom_range(0, 511));
          2: mem[i] = ins(14, $urandom_range(0, 511));
          3: mem[i] = ins(15, $urandom_range(0, 511));
          default: mem[i] = ins($urandom_range(0, 127), $urandom_range(0, 511));
        endcase
      end
      rst_off($urandom_range(0, 1));
      run(500, 80, 2, 5);
    end

    rst_on();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
